// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, state enum and request bundle for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: misalignment check, store lane shift/mask, load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  ofs,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        mis,
    output logic [31:0] wdata_sh,
    output logic [3:0]  wmask,
    output logic [31:0] rdata_ext
);

    logic [3:0]  base;
    logic [31:0] sh;

    assign sh       = rdata >> {ofs, 3'b000};
    assign wdata_sh = wdata << {ofs, 3'b000};
    assign wmask    = base << ofs;

    always_comb begin
        mis       = 1'b0;
        base      = 4'b0000;
        rdata_ext = sh;
        unique case (1'b1)
            (size == SZ_B): begin
                base      = 4'b0001;
                rdata_ext = {{24{~uns & sh[7]}}, sh[7:0]};
            end
            (size == SZ_H): begin
                base      = 4'b0011;
                mis       = ofs[0];
                rdata_ext = {{16{~uns & sh[15]}}, sh[15:0]};
            end
            (size == SZ_W): begin
                base = 4'b1111;
                mis  = |ofs;
            end
            default: mis = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: request/response FSM, wait-state counter and captured request registers.
module lsu
    import lsu_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    output logic        mem_wen,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_chk
        $error("lsu: LATENCY out of range 1..15");
    end

    state_t      state, state_nx;
    logic [3:0]  cnt;
    req_t        r;

    logic        a_mis;
    logic [31:0] a_wdata;
    logic [3:0]  a_wmask;
    logic [31:0] a_rdata;
    logic        idle;
    logic        fin;

    assign idle = (state == IDLE);
    assign fin  = (state == ACCESS) && (cnt == 4'd0);

    // Live inputs feed the legality check in IDLE; captured fields drive the access.
    lsu_align u_align (
        .size      (idle ? req_size : r.size),
        .ofs       (idle ? req_addr[1:0] : r.addr[1:0]),
        .uns       (r.uns),
        .wdata     (r.wdata),
        .rdata     (mem_rdata),
        .mis       (a_mis),
        .wdata_sh  (a_wdata),
        .wmask     (a_wmask),
        .rdata_ext (a_rdata)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_valid) state_nx = a_mis ? RESP : ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            r          <= '0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (idle && req_valid) begin
                r          <= '{req_wen, req_size, req_unsigned,
                                req_addr, req_wdata};
                cnt        <= 4'(LATENCY - 1);
                resp_rdata <= 32'd0;
                resp_err   <= a_mis;
            end else if (state == ACCESS) begin
                if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else if (!r.wen) resp_rdata <= a_rdata;
            end
        end
    end

    assign req_ready  = idle;
    assign resp_valid = (state == RESP);
    assign mem_valid  = fin;
    assign mem_wen    = fin & r.wen;
    assign mem_raddr  = fin ? {r.addr[31:2], 2'b00} : 32'd0;
    assign mem_waddr  = mem_raddr;
    assign mem_wdata  = fin ? a_wdata : 32'd0;
    assign mem_wmask  = fin ? {4'b0000, a_wmask} : 8'h00;

endmodule
